// File: rtl/button_irq_ctrl.sv
// Debounced three-button interrupt controller on a PicoBlaze-style port bus.
// Pending is set one edge after a debounced rise; the interrupt follows one edge later.
module button_irq_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 32000,
  parameter logic [7:0]  PORT_STATUS     = 8'h04,
  parameter logic [7:0]  PORT_MASK       = 8'h05
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic [7:0] port_id,
  input  logic       write_strobe,
  input  logic       read_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_data,
  output logic       in_valid,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  logic [2:0]         sync1_q, sync2_q;
  logic [2:0]         stable_q, stable_d;
  logic [2:0]         stable_prev_q;
  logic [2:0][CW-1:0] cnt_q, cnt_d;
  logic [2:0]         pending_q, pending_d;
  logic [2:0]         mask_q, mask_d;
  logic               irq_q, irq_d;
  state_t             state_q, state_d;
  logic [2:0]         clr;
  logic [2:0]         req;
  logic               unused_inputs;

  // Reads are side-effect free, so read_strobe is not needed.
  assign unused_inputs = ^{read_strobe, out_port[7:3]};

  // Counter reaching the last value means DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    clr       = (write_strobe && port_id == PORT_STATUS) ? out_port[2:0] : 3'b000;
    pending_d = (pending_q & ~clr) | (stable_q & ~stable_prev_q);
    mask_d    = (write_strobe && port_id == PORT_MASK) ? out_port[2:0] : mask_q;
    req       = pending_q & mask_q;
  end

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    case (state_q)
      S_IDLE: begin
        if (req != 3'b000) begin
          state_d = S_ASSERT;
          irq_d   = 1'b1;
        end
      end
      S_ASSERT: begin
        irq_d = 1'b1;
        if (interrupt_ack) begin
          state_d = S_SERVICE;
          irq_d   = 1'b0;
        end
      end
      S_SERVICE: begin
        irq_d = 1'b0;
        if (req == 3'b000) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      stable_q      <= 3'b000;
      stable_prev_q <= 3'b000;
      cnt_q         <= '0;
      pending_q     <= 3'b000;
      mask_q        <= 3'b111;
      irq_q         <= 1'b0;
      state_q       <= S_IDLE;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      mask_q        <= mask_d;
      irq_q         <= irq_d;
      state_q       <= state_d;
    end
  end

  always_comb begin
    in_data = 8'h00;
    if (port_id == PORT_STATUS) begin
      in_data = {stable_q, 2'b00, pending_q};
    end else if (port_id == PORT_MASK) begin
      in_data = {5'b00000, mask_q};
    end
  end

  assign in_valid  = (port_id == PORT_STATUS) || (port_id == PORT_MASK);
  assign interrupt = irq_q;

endmodule

// File: tb/tb_button_irq_ctrl.sv
// Bench for button_irq_ctrl: directed scenarios then random traffic against a reference model.
module tb_button_irq_ctrl;

  localparam int         DB = 4;
  localparam logic [7:0] PS = 8'h04;
  localparam logic [7:0] PM = 8'h05;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] btn = 3'b000;
  logic [7:0] port_id = PS;
  logic       write_strobe = 1'b0;
  logic       read_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_data;
  logic       in_valid;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;
  int bsel;

  // Reference model: debounced level, pending, mask, interrupt line and "being serviced" flag.
  logic [2:0] m_stable = 3'b000;
  logic [2:0] m_stable_prev = 3'b000;
  logic [2:0] m_pend = 3'b000;
  logic [2:0] m_mask = 3'b111;
  logic       m_irq = 1'b0;
  logic       m_serv = 1'b0;
  logic [2:0] hist[$];   // hist[0] is the btn sample taken at the latest edge

  button_irq_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .PORT_STATUS    (PS),
    .PORT_MASK      (PM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .port_id      (port_id),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .out_port     (out_port),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .interrupt    (interrupt),
    .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // A level is accepted once the last DB synchronized samples (2 edges old) agree and differ from it.
  task automatic model_edge();
    logic [2:0] ns, clr, req, smp, ref_s;
    logic       agree, n_irq, n_serv;
    if (reset) begin
      m_stable = 3'b000; m_stable_prev = 3'b000; m_pend = 3'b000;
      m_mask = 3'b111; m_irq = 1'b0; m_serv = 1'b0;
      hist.delete();
      for (int j = 0; j < DB + 2; j++) hist.push_back(3'b000);
      return;
    end
    hist.push_front(btn);
    void'(hist.pop_back());
    ns = m_stable;
    ref_s = hist[2];
    for (int i = 0; i < 3; i++) begin
      agree = 1'b1;
      for (int j = 3; j < DB + 2; j++) begin
        smp = hist[j];
        if (smp[i] != ref_s[i]) agree = 1'b0;
      end
      if (agree && ref_s[i] != m_stable[i]) ns[i] = ref_s[i];
    end
    clr = (write_strobe && port_id == PS) ? out_port[2:0] : 3'b000;
    req = m_pend & m_mask;
    n_irq = m_irq;
    n_serv = m_serv;
    if (m_irq) begin
      if (interrupt_ack) begin n_irq = 1'b0; n_serv = 1'b1; end
    end else if (m_serv) begin
      if (req == 3'b000) n_serv = 1'b0;
    end else if (req != 3'b000) begin
      n_irq = 1'b1;
    end
    m_pend = (m_pend & ~clr) | (m_stable & ~m_stable_prev);
    if (write_strobe && port_id == PM) m_mask = out_port[2:0];
    m_stable_prev = m_stable;
    m_stable = ns;
    m_irq = n_irq;
    m_serv = n_serv;
  endtask

  function automatic logic [7:0] exp_data(input logic [7:0] pid);
    if (pid == PS) return {m_stable, 2'b00, m_pend};
    if (pid == PM) return {5'b00000, m_mask};
    return 8'h00;
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1 model_edge();
    @(negedge clk);
    chk("in_data", in_data, exp_data(port_id));
    chk("in_valid", {7'b0, in_valid}, {7'b0, (port_id == PS) || (port_id == PM)});
    chk("interrupt", {7'b0, interrupt}, {7'b0, m_irq});
  endtask

  initial begin
    for (int j = 0; j < DB + 2; j++) hist.push_back(3'b000);
    repeat (2) cycle();
    reset = 1'b0;
    chk("rst_status", in_data, 8'h00);
    port_id = PM;
    #1 chk("rst_mask", in_data, 8'h07);
    port_id = PS;

    // Held press on btn[0]
    btn = 3'b001;
    repeat (6) cycle();
    chk("e6_status", in_data, 8'h20);
    cycle();
    chk("e7_status", in_data, 8'h21);
    chk("e7_irq", {7'b0, interrupt}, 8'h00);
    cycle();
    chk("e8_irq", {7'b0, interrupt}, 8'h01);
    repeat (3) cycle();
    chk("irq_hold", {7'b0, interrupt}, 8'h01);

    // Ack then W1C
    interrupt_ack = 1'b1;
    cycle();
    interrupt_ack = 1'b0;
    chk("ack_drop", {7'b0, interrupt}, 8'h00);
    write_strobe = 1'b1; out_port = 8'h01;
    cycle();
    write_strobe = 1'b0; out_port = 8'h00;
    chk("w1c_status", in_data, 8'h20);
    repeat (5) cycle();
    chk("no_reassert", {7'b0, interrupt}, 8'h00);

    // Short glitch on btn[1]
    btn = 3'b011;
    repeat (3) cycle();
    btn = 3'b001;
    repeat (8) cycle();
    chk("glitch_status", in_data, 8'h20);
    chk("glitch_irq", {7'b0, interrupt}, 8'h00);

    // Masking
    port_id = PM; write_strobe = 1'b1; out_port = 8'h00;
    cycle();
    write_strobe = 1'b0;
    chk("mask0", in_data, 8'h00);
    btn = 3'b000; port_id = PS;
    repeat (8) cycle();
    chk("release_status", in_data, 8'h00);
    btn = 3'b100;
    repeat (10) cycle();
    chk("masked_status", in_data, 8'h84);
    chk("masked_irq", {7'b0, interrupt}, 8'h00);
    port_id = PM; write_strobe = 1'b1; out_port = 8'h04;
    cycle();
    write_strobe = 1'b0;
    chk("unmask_e0", {7'b0, interrupt}, 8'h00);
    cycle();
    chk("unmask_e1", {7'b0, interrupt}, 8'h01);

    // Set/clear collision on pending[0]
    interrupt_ack = 1'b1;
    cycle();
    interrupt_ack = 1'b0;
    port_id = PS; write_strobe = 1'b1; out_port = 8'h04;
    cycle();
    write_strobe = 1'b0;
    btn = 3'b101;
    repeat (6) cycle();
    write_strobe = 1'b1; out_port = 8'h01;
    cycle();
    write_strobe = 1'b0; out_port = 8'h00;
    chk("collision", in_data, 8'hA1);

    // Reset with the interrupt raised
    port_id = PM; write_strobe = 1'b1; out_port = 8'h07;
    cycle();
    write_strobe = 1'b0;
    cycle();
    chk("pre_rst_irq", {7'b0, interrupt}, 8'h01);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("rst_irq", {7'b0, interrupt}, 8'h00);
    port_id = PS;
    #1 chk("rst_status2", in_data, 8'h00);
    port_id = PM;
    #1 chk("rst_mask2", in_data, 8'h07);
    btn = 3'b000;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bsel = int'($urandom_range(0, 2));
        btn[bsel] = ~btn[bsel];
      end
      case ($urandom_range(0, 3))
        0, 1:    port_id = PS;
        2:       port_id = PM;
        default: port_id = 8'($urandom);
      endcase
      write_strobe  = ($urandom_range(0, 5) == 0);
      out_port      = 8'($urandom);
      read_strobe   = 1'($urandom_range(0, 1));
      interrupt_ack = ($urandom_range(0, 4) == 0);
      reset         = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
